present_round_ctrl: RTL

//   Sequencer for the iterative PRESENT-128 round datapath. Owns the round counter and the

---
 rtl/present_round_ctrl_pkg.sv | 14 +
 rtl/present_round_ctr.sv | 25 ++
 rtl/present_round_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/present_round_ctrl_pkg.sv
// Shared constants and FSM encoding for the PRESENT-128 round sequencer.
// The round datapath and the key schedule use the same round count and counter width.
package present_round_ctrl_pkg;
  localparam int PRESENT_ROUNDS = 31;
  localparam int PRESENT_RC_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/present_round_ctr.sv
// Round counter: load-to-1, increment, clear, and terminal count at ROUNDS.
module present_round_ctr
  import present_round_ctrl_pkg::*;
#(
  parameter int ROUNDS = PRESENT_ROUNDS,
  parameter int RC_W   = PRESENT_RC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_one,
  input  logic            inc,
  input  logic            clr,
  output logic [RC_W-1:0] ctr,
  output logic            tc
);

  always_ff @(posedge clk) begin
    if (rst || clr)   ctr <= '0;
    else if (set_one) ctr <= RC_W'(1);
    else if (inc)     ctr <= ctr + RC_W'(1);
  end

  assign tc = (ctr == RC_W'(ROUNDS));

endmodule

// File: rtl/present_round_ctrl.sv
// Sequencer for the iterative PRESENT-128 datapath: load, ROUNDS rounds, final key add,
// then hold the ciphertext valid until acknowledged.
module present_round_ctrl
  import present_round_ctrl_pkg::*;
#(
  parameter int ROUNDS = PRESENT_ROUNDS,
  parameter int RC_W   = PRESENT_RC_W,
  parameter int CNT_W  = 16
) (
  input  logic             sig_mstr_clk,
  input  logic             sig_in_rst,
  input  logic             sig_in_load,
  input  logic             sig_in_ack,
  output logic             sig_out_ready,
  output logic             sig_out_sel_load,
  output logic             sig_out_round_en,
  output logic [RC_W-1:0]  sig_out_round_ctr,
  output logic             sig_out_final,
  output logic             sig_out_valid,
  output logic [CNT_W-1:0] sig_out_blk_cnt
);

  state_e state;
  logic   tc;
  logic   legal;

  assign legal = state inside {ST_IDLE, ST_LOAD, ST_ROUND, ST_FINAL, ST_DONE};

  // The counter is cleared leaving FINAL and whenever the state register is corrupt.
  present_round_ctr #(.ROUNDS(ROUNDS), .RC_W(RC_W)) u_ctr (
    .clk     (sig_mstr_clk),
    .rst     (sig_in_rst),
    .set_one (state == ST_IDLE && sig_in_load),
    .inc     (state == ST_ROUND && !tc),
    .clr     (state == ST_FINAL || !legal),
    .ctr     (sig_out_round_ctr),
    .tc      (tc)
  );

  // Outputs are registered alongside the state so each one tracks the state it decodes.
  always_ff @(posedge sig_mstr_clk) begin
    if (sig_in_rst) begin
      state            <= ST_IDLE;
      sig_out_ready    <= 1'b1;
      sig_out_sel_load <= 1'b0;
      sig_out_round_en <= 1'b0;
      sig_out_final    <= 1'b0;
      sig_out_valid    <= 1'b0;
      sig_out_blk_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (sig_in_load) begin
          state            <= ST_LOAD;
          sig_out_ready    <= 1'b0;
          sig_out_sel_load <= 1'b1;
        end
        ST_LOAD: begin
          state            <= ST_ROUND;
          sig_out_sel_load <= 1'b0;
          sig_out_round_en <= 1'b1;
        end
        ST_ROUND: if (tc) begin
          state            <= ST_FINAL;
          sig_out_round_en <= 1'b0;
          sig_out_final    <= 1'b1;
        end
        ST_FINAL: begin
          state         <= ST_DONE;
          sig_out_final <= 1'b0;
          sig_out_valid <= 1'b1;
        end
        ST_DONE: if (sig_in_ack) begin
          state           <= ST_IDLE;
          sig_out_valid   <= 1'b0;
          sig_out_ready   <= 1'b1;
          sig_out_blk_cnt <= sig_out_blk_cnt + CNT_W'(1);
        end
        default: begin
          state            <= ST_IDLE;
          sig_out_ready    <= 1'b1;
          sig_out_sel_load <= 1'b0;
          sig_out_round_en <= 1'b0;
          sig_out_final    <= 1'b0;
          sig_out_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule
